// File: rtl/dyn_phase_pkg.sv
// Shared types and constants for the dynamic-phase Avalon-MM initiator and its slave.
package dyn_phase_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_CNT,
    ST_WR_PH,
    ST_RD_PH,
    ST_CHECK,
    ST_GAP,
    ST_FIN,
    ST_ERR
  } state_t;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_MISMATCH = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd2;

  localparam logic [ADDR_W-1:0] DEF_COUNTER_ADDR = 16'h0000;
  localparam logic [ADDR_W-1:0] DEF_PHASE_ADDR   = 16'h0004;

  localparam int unsigned PH_STEP_BIT   = 0;
  localparam int unsigned PH_UPDOWN_BIT = 1;

  typedef struct packed {
    logic              rnw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } xfer_req_t;

  // Phase register value requesting one step in the given direction.
  function automatic logic [DATA_W-1:0] phase_word(input logic dir);
    logic [DATA_W-1:0] w;
    w                = '0;
    w[PH_STEP_BIT]   = 1'b1;
    w[PH_UPDOWN_BIT] = dir;
    return w;
  endfunction

endpackage

// File: rtl/dyn_phase_master_xfer.sv
// Single Avalon-MM transfer engine: begin/hold strobes, completion capture, waitrequest timeout.
module avm_xfer
  import dyn_phase_pkg::*;
#(
  parameter int unsigned P_TIMEOUT = 64
) (
  input  logic              CLK100M,
  input  logic              RESET,
  input  logic              go,
  input  xfer_req_t         req,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              timeout,
  output logic              AVM_CS,
  output logic              AVM_BEGINTRANSFER,
  output logic [ADDR_W-1:0] AVM_ADDRESS,
  output logic              AVM_READ,
  output logic              AVM_WRITE,
  output logic [DATA_W-1:0] AVM_WRITEDATA,
  input  logic [DATA_W-1:0] AVM_READDATA,
  input  logic              AVM_WAITREQUEST
);

  localparam int unsigned TW = 8;

  logic [TW-1:0] wait_cnt;

  // Cycle index within the current transfer doubles as the timeout counter.
  always_ff @(posedge CLK100M) begin
    if (RESET) begin
      done              <= 1'b0;
      timeout           <= 1'b0;
      rdata             <= '0;
      wait_cnt          <= '0;
      AVM_CS            <= 1'b0;
      AVM_BEGINTRANSFER <= 1'b0;
      AVM_ADDRESS       <= '0;
      AVM_READ          <= 1'b0;
      AVM_WRITE         <= 1'b0;
      AVM_WRITEDATA     <= '0;
    end else begin
      done              <= 1'b0;
      timeout           <= 1'b0;
      AVM_BEGINTRANSFER <= 1'b0;
      if (AVM_CS) begin
        if (!AVM_WAITREQUEST || (wait_cnt == TW'(P_TIMEOUT - 1))) begin
          done          <= !AVM_WAITREQUEST;
          timeout       <= AVM_WAITREQUEST;
          AVM_CS        <= 1'b0;
          AVM_READ      <= 1'b0;
          AVM_WRITE     <= 1'b0;
          AVM_ADDRESS   <= '0;
          AVM_WRITEDATA <= '0;
          if (!AVM_WAITREQUEST) begin
            rdata <= AVM_READDATA;
          end
        end else begin
          wait_cnt <= wait_cnt + 1'b1;
        end
      end else if (go) begin
        AVM_CS            <= 1'b1;
        AVM_BEGINTRANSFER <= 1'b1;
        AVM_READ          <= req.rnw;
        AVM_WRITE         <= !req.rnw;
        AVM_ADDRESS       <= req.addr;
        AVM_WRITEDATA     <= req.rnw ? '0 : req.data;
        wait_cnt          <= '0;
      end
    end
  end

endmodule

// File: rtl/dyn_phase_master.sv
// Sequences a counter-select write and N verified phase steps through the transfer engine.
module dyn_phase_master
  import dyn_phase_pkg::*;
#(
  parameter logic [15:0] P_COUNTER_ADDR = DEF_COUNTER_ADDR,
  parameter logic [15:0] P_PHASE_ADDR   = DEF_PHASE_ADDR,
  parameter int unsigned P_STEP_GAP     = 16,
  parameter int unsigned P_TIMEOUT      = 64
) (
  input  logic        CLK100M,
  input  logic        RESET,
  input  logic        START,
  input  logic [3:0]  COUNTER_SEL,
  input  logic        DIRECTION,
  input  logic [7:0]  STEP_COUNT,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERROR,
  output logic [1:0]  ERR_CODE,
  output logic [7:0]  STEPS_DONE,
  output logic        AVM_CS,
  output logic        AVM_BEGINTRANSFER,
  output logic [15:0] AVM_ADDRESS,
  output logic        AVM_READ,
  output logic        AVM_WRITE,
  output logic [31:0] AVM_WRITEDATA,
  input  logic [31:0] AVM_READDATA,
  input  logic        AVM_WAITREQUEST
);

  state_t      state;
  logic        dir_q;
  logic [7:0]  remaining;
  logic [7:0]  gap_cnt;
  logic        go;
  xfer_req_t   req;
  logic        x_done;
  logic        x_timeout;
  logic [31:0] x_rdata;

  always_ff @(posedge CLK100M) begin
    if (RESET) begin
      state      <= ST_IDLE;
      dir_q      <= 1'b0;
      remaining  <= '0;
      gap_cnt    <= '0;
      go         <= 1'b0;
      req        <= '0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
      ERROR      <= 1'b0;
      ERR_CODE   <= ERR_NONE;
      STEPS_DONE <= '0;
    end else begin
      go   <= 1'b0;
      DONE <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (START) begin
            dir_q      <= DIRECTION;
            remaining  <= STEP_COUNT;
            ERROR      <= 1'b0;
            ERR_CODE   <= ERR_NONE;
            STEPS_DONE <= '0;
            BUSY       <= 1'b1;
            req        <= '{rnw: 1'b0, addr: P_COUNTER_ADDR, data: {28'd0, COUNTER_SEL}};
            go         <= 1'b1;
            state      <= ST_WR_CNT;
          end
        end
        ST_WR_CNT, ST_WR_PH, ST_RD_PH: begin
          if (x_timeout) begin
            ERROR    <= 1'b1;
            ERR_CODE <= ERR_TIMEOUT;
            BUSY     <= 1'b0;
            state    <= ST_ERR;
          end else if (x_done) begin
            if (state == ST_RD_PH) begin
              state <= ST_CHECK;
            end else if (state == ST_WR_PH) begin
              req   <= '{rnw: 1'b1, addr: P_PHASE_ADDR, data: '0};
              go    <= 1'b1;
              state <= ST_RD_PH;
            end else if (remaining != '0) begin
              req   <= '{rnw: 1'b0, addr: P_PHASE_ADDR, data: phase_word(dir_q)};
              go    <= 1'b1;
              state <= ST_WR_PH;
            end else begin
              DONE  <= 1'b1;
              BUSY  <= 1'b0;
              state <= ST_FIN;
            end
          end
        end
        // Read-back must match exactly what was written, including the zero upper bits.
        ST_CHECK: begin
          if (x_rdata == phase_word(dir_q)) begin
            STEPS_DONE <= STEPS_DONE + 8'd1;
            remaining  <= remaining - 8'd1;
            gap_cnt    <= '0;
            state      <= ST_GAP;
          end else begin
            ERROR    <= 1'b1;
            ERR_CODE <= ERR_MISMATCH;
            BUSY     <= 1'b0;
            state    <= ST_ERR;
          end
        end
        ST_GAP: begin
          if (gap_cnt == 8'(P_STEP_GAP - 1)) begin
            if (remaining != '0) begin
              req   <= '{rnw: 1'b0, addr: P_PHASE_ADDR, data: phase_word(dir_q)};
              go    <= 1'b1;
              state <= ST_WR_PH;
            end else begin
              DONE  <= 1'b1;
              BUSY  <= 1'b0;
              state <= ST_FIN;
            end
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end
        ST_FIN:  state <= ST_IDLE;
        ST_ERR:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  avm_xfer #(
    .P_TIMEOUT (P_TIMEOUT)
  ) u_xfer (
    .CLK100M           (CLK100M),
    .RESET             (RESET),
    .go                (go),
    .req               (req),
    .done              (x_done),
    .rdata             (x_rdata),
    .timeout           (x_timeout),
    .AVM_CS            (AVM_CS),
    .AVM_BEGINTRANSFER (AVM_BEGINTRANSFER),
    .AVM_ADDRESS       (AVM_ADDRESS),
    .AVM_READ          (AVM_READ),
    .AVM_WRITE         (AVM_WRITE),
    .AVM_WRITEDATA     (AVM_WRITEDATA),
    .AVM_READDATA      (AVM_READDATA),
    .AVM_WAITREQUEST   (AVM_WAITREQUEST)
  );

endmodule

// File: tb/tb_dyn_phase_master.sv
// Self-checking bench: slave model, protocol monitor and a transaction-level model of a phase sweep.
module tb_dyn_phase_master;

  localparam int unsigned GAP = 16;
  localparam int unsigned TMO = 64;

  typedef struct packed {
    logic        rnw;
    logic [15:0] addr;
    logic [31:0] data;
  } rec_t;

  logic        CLK100M = 1'b0;
  logic        RESET = 1'b1;
  logic        START = 1'b0;
  logic [3:0]  COUNTER_SEL = '0;
  logic        DIRECTION = 1'b0;
  logic [7:0]  STEP_COUNT = '0;
  logic        BUSY, DONE, ERROR;
  logic [1:0]  ERR_CODE;
  logic [7:0]  STEPS_DONE;
  logic        AVM_CS, AVM_BEGINTRANSFER, AVM_READ, AVM_WRITE;
  logic [15:0] AVM_ADDRESS;
  logic [31:0] AVM_WRITEDATA, AVM_READDATA;
  logic        AVM_WAITREQUEST;

  int total = 0;
  int bad = 0;

  dyn_phase_master #(
    .P_STEP_GAP (GAP),
    .P_TIMEOUT  (TMO)
  ) dut (
    .CLK100M           (CLK100M),
    .RESET             (RESET),
    .START             (START),
    .COUNTER_SEL       (COUNTER_SEL),
    .DIRECTION         (DIRECTION),
    .STEP_COUNT        (STEP_COUNT),
    .BUSY              (BUSY),
    .DONE              (DONE),
    .ERROR             (ERROR),
    .ERR_CODE          (ERR_CODE),
    .STEPS_DONE        (STEPS_DONE),
    .AVM_CS            (AVM_CS),
    .AVM_BEGINTRANSFER (AVM_BEGINTRANSFER),
    .AVM_ADDRESS       (AVM_ADDRESS),
    .AVM_READ          (AVM_READ),
    .AVM_WRITE         (AVM_WRITE),
    .AVM_WRITEDATA     (AVM_WRITEDATA),
    .AVM_READDATA      (AVM_READDATA),
    .AVM_WAITREQUEST   (AVM_WAITREQUEST)
  );

  always #5 CLK100M = ~CLK100M;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Slave model: ws wait states per transfer, optional permanent stalls, optional forced read value.
  int          ws = 1;
  bit          hold_all = 0;
  bit          hold_ph_wr = 0;
  bit          force_en = 0;
  int          force_idx = 0;
  logic [31:0] force_val = '0;
  logic [31:0] phase_reg = '0;
  int          rd_idx = 0;
  int          xcnt = 0;

  always_comb begin
    AVM_WAITREQUEST = AVM_CS && (hold_all || (hold_ph_wr && AVM_WRITE && AVM_ADDRESS == 16'h0004)
                                 || (xcnt < ws));
    AVM_READDATA = (force_en && rd_idx == force_idx) ? force_val : phase_reg;
  end

  always @(posedge CLK100M) begin
    if (RESET || !AVM_CS) xcnt <= 0;
    else if (AVM_WAITREQUEST) xcnt <= xcnt + 1;
    else begin
      xcnt <= 0;
      if (AVM_WRITE && AVM_ADDRESS == 16'h0004) phase_reg <= AVM_WRITEDATA;
      if (AVM_READ) rd_idx <= rd_idx + 1;
    end
  end

  // Protocol monitor: checks every cycle, logs completed transfers.
  int          cyc = 0;
  bit          prev_cs = 0;
  logic [49:0] prev_hold = '0;
  int          cs_run = 0;
  int          last_run = 0;
  int          done_cnt = 0;
  int          last_rd_end = 0;
  bit          rd_seen = 0;
  bit          chk_len_en = 1;
  rec_t        got[$];

  always @(negedge CLK100M) begin
    rec_t r;
    cyc++;
    if (DONE) begin
      done_cnt++;
      check("done_with_busy_low", 32'(BUSY), 32'd0);
    end
    if (AVM_CS) begin
      check("one_strobe", 32'(AVM_READ ^ AVM_WRITE), 32'd1);
      check("begin_first_cycle_only", 32'(AVM_BEGINTRANSFER), 32'(!prev_cs));
      if (prev_cs)
        check("hold_while_wait", 32'({AVM_READ, AVM_WRITE, AVM_ADDRESS, AVM_WRITEDATA} != prev_hold), 32'd0);
      if (!prev_cs && AVM_ADDRESS == 16'h0000) rd_seen = 0;
      if (!prev_cs && AVM_WRITE && AVM_ADDRESS == 16'h0004 && rd_seen) begin
        check("step_gap_min", 32'((cyc - last_rd_end - 1) >= int'(GAP)), 32'd1);
        rd_seen = 0;
      end
      cs_run++;
      if (!AVM_WAITREQUEST) begin
        r.rnw  = AVM_READ;
        r.addr = AVM_ADDRESS;
        r.data = AVM_READ ? AVM_READDATA : AVM_WRITEDATA;
        got.push_back(r);
        if (chk_len_en) check("xfer_len", 32'(cs_run), 32'(ws + 1));
        if (AVM_READ) begin
          last_rd_end = cyc;
          rd_seen = 1;
        end
      end
    end else begin
      check("idle_strobes", 32'({AVM_BEGINTRANSFER, AVM_READ, AVM_WRITE}), 32'd0);
      if (prev_cs) last_run = cs_run;
      cs_run = 0;
    end
    prev_cs   = AVM_CS;
    prev_hold = {AVM_READ, AVM_WRITE, AVM_ADDRESS, AVM_WRITEDATA};
  end

  // Transaction-level model of one sweep.
  rec_t exp_q[$];
  int   exp_steps;
  int   exp_code;

  task automatic model_seq(input logic [3:0] sel, input logic dir, input int n,
                           input int bad_step, input logic [31:0] bad_val);
    rec_t        r;
    logic [31:0] good, rd;
    good = {30'd0, dir, 1'b1};
    exp_q.delete();
    exp_steps = 0;
    exp_code  = 0;
    r = '{rnw: 1'b0, addr: 16'h0000, data: {28'd0, sel}};
    exp_q.push_back(r);
    for (int i = 1; i <= n; i++) begin
      r = '{rnw: 1'b0, addr: 16'h0004, data: good};
      exp_q.push_back(r);
      rd = (i == bad_step) ? bad_val : good;
      r = '{rnw: 1'b1, addr: 16'h0004, data: rd};
      exp_q.push_back(r);
      if (rd != good) begin
        exp_code = 1;
        break;
      end
      exp_steps++;
    end
  endtask

  task automatic run_seq(input string tag, input logic [3:0] sel, input logic dir, input int n,
                         input int bad_step, input logic [31:0] bad_val, input int restart_at);
    int gbase, dbase, ng;
    bit fin;
    model_seq(sel, dir, n, bad_step, bad_val);
    force_en  = (bad_step != 0);
    force_idx = rd_idx + bad_step - 1;
    force_val = bad_val;
    gbase = got.size();
    dbase = done_cnt;
    @(negedge CLK100M);
    COUNTER_SEL = sel;
    DIRECTION   = dir;
    STEP_COUNT  = 8'(n);
    START       = 1'b1;
    @(negedge CLK100M);
    START = 1'b0;
    check({tag, "_busy_after_start"}, 32'(BUSY), 32'd1);
    check({tag, "_error_cleared"}, 32'(ERROR), 32'd0);
    fin = 0;
    for (int i = 0; i < 20000 && !fin; i++) begin
      if (i == restart_at) begin
        START = 1'b1;
        COUNTER_SEL = 4'hA;
        DIRECTION = ~dir;
        STEP_COUNT = 8'd7;
      end else START = 1'b0;
      if ((DONE || ERROR) && !BUSY) fin = 1;
      else @(negedge CLK100M);
    end
    if (!fin) begin
      total++;
      bad++;
      $display("FAIL %s_wait: no DONE/ERROR within cycle budget", tag);
    end
    check({tag, "_steps_done"}, 32'(STEPS_DONE), 32'(exp_steps));
    check({tag, "_err_code"}, 32'(ERR_CODE), 32'(exp_code));
    check({tag, "_error"}, 32'(ERROR), 32'(exp_code != 0));
    // START while in FIN/ERR must be ignored.
    START = 1'b1;
    @(negedge CLK100M);
    START = 1'b0;
    check({tag, "_fin_start_ignored"}, 32'(BUSY), 32'd0);
    repeat (30) @(negedge CLK100M);
    force_en = 0;
    check({tag, "_done_pulses"}, 32'(done_cnt - dbase), 32'(exp_code == 0));
    ng = got.size() - gbase;
    check({tag, "_xfer_count"}, 32'(ng), 32'(exp_q.size()));
    for (int k = 0; k < exp_q.size() && k < ng; k++) begin
      check($sformatf("%s_x%0d_rnw", tag, k), 32'(got[gbase + k].rnw), 32'(exp_q[k].rnw));
      check($sformatf("%s_x%0d_addr", tag, k), 32'(got[gbase + k].addr), 32'(exp_q[k].addr));
      check($sformatf("%s_x%0d_data", tag, k), got[gbase + k].data, exp_q[k].data);
    end
  endtask

  initial begin
    int gbase;
    bit seen;
    RESET = 1'b1;
    repeat (3) @(negedge CLK100M);
    check("reset_outputs", 32'({BUSY, DONE, ERROR, ERR_CODE, STEPS_DONE, AVM_CS, AVM_BEGINTRANSFER,
                                AVM_READ, AVM_WRITE}), 32'd0);
    check("reset_addr_data", 32'(AVM_ADDRESS) | AVM_WRITEDATA, 32'd0);
    RESET = 1'b0;
    repeat (2) @(negedge CLK100M);

    run_seq("basic", 4'h5, 1'b1, 3, 0, 32'd0, -1);
    check("basic_model_len", 32'(exp_q.size()), 32'd7);
    check("basic_model_cnt_data", exp_q[0].data, 32'h5);
    check("basic_model_ph_data", exp_q[1].data, 32'h3);
    check("basic_steps_literal", 32'(STEPS_DONE), 32'd3);

    run_seq("zero", 4'h9, 1'b1, 0, 0, 32'd0, -1);
    check("zero_model_len", 32'(exp_q.size()), 32'd1);

    run_seq("down", 4'h6, 1'b0, 2, 0, 32'd0, -1);
    check("down_model_ph_data", exp_q[1].data, 32'h1);

    run_seq("mism", 4'h5, 1'b1, 3, 2, 32'h1, -1);
    check("mism_code_literal", 32'(ERR_CODE), 32'd1);
    check("mism_steps_literal", 32'(STEPS_DONE), 32'd1);

    // Waitrequest stuck high: abort after the timeout window.
    hold_all = 1;
    chk_len_en = 0;
    gbase = got.size();
    @(negedge CLK100M);
    COUNTER_SEL = 4'h2;
    DIRECTION = 1'b1;
    STEP_COUNT = 8'd1;
    START = 1'b1;
    @(negedge CLK100M);
    START = 1'b0;
    check("tmo_error_cleared", 32'(ERROR), 32'd0);
    seen = 0;
    for (int i = 0; i < 500 && !seen; i++) begin
      if (ERROR && !BUSY) seen = 1;
      else @(negedge CLK100M);
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL tmo_wait: no ERROR within cycle budget");
    end
    check("tmo_err_code", 32'(ERR_CODE), 32'd2);
    check("tmo_busy", 32'(BUSY), 32'd0);
    check("tmo_cs_cycles", 32'(last_run), 32'(TMO));
    check("tmo_no_completion", 32'(got.size() - gbase), 32'd0);
    hold_all = 0;
    repeat (5) @(negedge CLK100M);

    // Reset during a stalled phase write.
    hold_ph_wr = 1;
    chk_len_en = 1;
    ws = 1;
    @(negedge CLK100M);
    COUNTER_SEL = 4'h3;
    DIRECTION = 1'b0;
    STEP_COUNT = 8'd2;
    START = 1'b1;
    @(negedge CLK100M);
    START = 1'b0;
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      if (AVM_CS && AVM_WRITE && AVM_ADDRESS == 16'h0004 && cs_run >= 3) seen = 1;
      else @(negedge CLK100M);
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL rst_wait: stalled phase write never observed");
    end
    RESET = 1'b1;
    @(negedge CLK100M);
    check("rst_avm_strobes", 32'({AVM_CS, AVM_BEGINTRANSFER, AVM_READ, AVM_WRITE}), 32'd0);
    check("rst_avm_addr_data", 32'(AVM_ADDRESS) | AVM_WRITEDATA, 32'd0);
    check("rst_status", 32'({BUSY, DONE, ERROR, ERR_CODE}), 32'd0);
    check("rst_steps_done", 32'(STEPS_DONE), 32'd0);
    RESET = 1'b0;
    hold_ph_wr = 0;
    repeat (3) @(negedge CLK100M);
    run_seq("after_rst", 4'h3, 1'b0, 1, 0, 32'd0, -1);

    // Zero-wait slave, with a second START while busy.
    ws = 0;
    run_seq("zw_restart", 4'h7, 1'b1, 2, 0, 32'd0, 5);
    run_seq("max", 4'h1, 1'b1, 255, 0, 32'd0, -1);
    check("max_steps_literal", 32'(STEPS_DONE), 32'd255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
